sao_readback: RTL and testbench

Frame readback engine for the SAO output memory. After the SAO filter finishes a frame, it reads all 16384 pixels of the 128x128 frame back out of the sram_16384x8 port. It streams the pixels on a valid/ready interface in either raster order or LCU-tile order, which lets the output be compared against a golden image or passed downstream. It is the read-side counterpart of the SAO write path and shares the same CEN/WEN/A convention.

---
 rtl/sao_readback_if.sv | 24 ++
 rtl/sao_readback.sv | 144 ++++++++++++++
 tb/tb_sao_readback.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sao_readback_if.sv
// SRAM read port and pixel output stream of the SAO frame readback engine.
interface sao_readback_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8
);
    logic              cen;
    logic              wen;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] q;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output cen, wen, a, out_valid, out_data, out_addr,
        input  q, out_ready
    );

    modport slave (
        input  cen, wen, a, out_valid, out_data, out_addr,
        output q, out_ready
    );
endinterface

// File: rtl/sao_readback.sv
// Reads a FRAME_W x FRAME_W frame from SRAM and streams it in raster or LCU-tile order.
// Optional frame checksum is built when SAO_RB_CHECKSUM_EN is defined.
module sao_readback #(
    parameter int unsigned FRAME_W = 128,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned DATA_W  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_start,
    input  logic           i_scan_mode,
    input  logic [1:0]     i_lcu_size,
    output logic           o_busy,
    output logic           o_done,
    output logic [15:0]    o_checksum,
    sao_readback_if.master bus
);
    localparam int unsigned LOG_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e            r_state, w_state_d;
    logic              r_mode;
    logic [2:0]        r_sh;
    logic [LOG_W-1:0]  r_c, r_r, r_lx, r_ly;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inflight_addr;
    logic [ADDR_W-1:0] r_a;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_addr [2];
    logic              r_wr_ptr, r_rd_ptr;
    logic [1:0]        r_count;

    logic              w_accept, w_issue, w_pop, w_valid, w_last, w_drained;
    logic [LOG_W-1:0]  w_s_max, w_t_max;
    logic [ADDR_W-1:0] w_row, w_col, w_addr;

    // Raster mode reuses the tile counters with one full-frame tile.
    assign w_s_max = r_mode ? LOG_W'((32'd1 << r_sh) - 32'd1) : LOG_W'(FRAME_W - 32'd1);
    assign w_t_max = r_mode ? LOG_W'((FRAME_W >> r_sh) - 32'd1) : '0;
    assign w_row   = (ADDR_W'(r_ly) << r_sh) + ADDR_W'(r_r);
    assign w_col   = (ADDR_W'(r_lx) << r_sh) + ADDR_W'(r_c);
    assign w_addr  = (w_row << LOG_W) + w_col;
    assign w_last  = (r_c == w_s_max) && (r_r == w_s_max) &&
                     (r_lx == w_t_max) && (r_ly == w_t_max);

    assign w_valid   = (r_count != 2'd0);
    assign w_pop     = w_valid && bus.out_ready;
    assign w_accept  = (r_state == StIdle) && i_start && (i_lcu_size != 2'd3);
    assign w_drained = (r_count == 2'd0) && !r_inflight;
    // Slot freed by a same-cycle pop may be refilled immediately.
    assign w_issue   = !reset && (r_state == StRun) &&
                       ((r_count - 2'(w_pop) + 2'(r_inflight)) <= 2'd1);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StRun;
            StRun:   if (w_issue && w_last) w_state_d = StDrain;
            StDrain: if (w_drained) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= StIdle;
            r_mode          <= 1'b0;
            r_sh            <= 3'd4;
            r_c             <= '0;
            r_r             <= '0;
            r_lx            <= '0;
            r_ly            <= '0;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_a             <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_count         <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_mode <= i_scan_mode;
                r_sh   <= 3'(i_lcu_size) + 3'd4;
                r_c    <= '0;
                r_r    <= '0;
                r_lx   <= '0;
                r_ly   <= '0;
            end else if (w_issue) begin
                r_a             <= w_addr;
                r_inflight_addr <= w_addr;
                if (r_c != w_s_max) r_c <= r_c + 1'b1;
                else begin
                    r_c <= '0;
                    if (r_r != w_s_max) r_r <= r_r + 1'b1;
                    else begin
                        r_r <= '0;
                        if (r_lx != w_t_max) r_lx <= r_lx + 1'b1;
                        else begin
                            r_lx <= '0;
                            if (r_ly != w_t_max) r_ly <= r_ly + 1'b1;
                            else r_ly <= '0;
                        end
                    end
                end
            end
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= bus.q;
                r_fifo_addr[r_wr_ptr] <= r_inflight_addr;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + 2'(r_inflight) - 2'(w_pop);
        end
    end

    assign bus.cen       = !w_issue;
    assign bus.wen       = 1'b1;
    assign bus.a         = w_issue ? w_addr : r_a;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = r_fifo_data[r_rd_ptr];
    assign bus.out_addr  = r_fifo_addr[r_rd_ptr];
    assign o_busy        = (r_state != StIdle);
    assign o_done        = !reset && (r_state == StDrain) && w_drained;

`ifdef SAO_RB_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset)         r_sum <= '0;
        else if (w_accept) r_sum <= '0;
        else if (w_pop)    r_sum <= r_sum + 16'(r_fifo_data[r_rd_ptr]);
    end

    assign o_checksum = r_sum;
`else
    assign o_checksum = 16'd0;
`endif
endmodule

// File: tb/tb_sao_readback.sv
// Randomized self-checking bench for sao_readback against an arithmetic address/data model.
module tb_sao_readback;
    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic        i_scan_mode;
    logic [1:0]  i_lcu_size;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_checksum;

    sao_readback_if #(.ADDR_W(14), .DATA_W(8)) bus ();

    sao_readback #(.FRAME_W(128), .ADDR_W(14), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (i_start),
        .i_scan_mode(i_scan_mode),
        .i_lcu_size (i_lcu_size),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_checksum (o_checksum),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [N];
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.cen == 1'b0) bus.q <= mem[bus.a];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model state for the frame under test
    bit        cur_mode    = 1'b0;
    int        cur_s       = 16;
    int        pix         = 0;
    int        iss         = 0;
    int        first_cen   = -1;
    int        first_valid = -1;
    int        done_cnt    = 0;
    int        done_cyc    = -1;
    int        cs_at_done  = 0;
    bit        prev_stall  = 1'b0;
    bit        rnd_ready   = 1'b0;
    logic [7:0]  held_d;
    logic [13:0] held_a;
    int        obs_addr [N];

    function automatic int exp_addr(input bit mode, input int s, input int k);
        int t, p, tiles;
        if (!mode) return k;
        tiles = 128 / s;
        t = k / (s * s);
        p = k % (s * s);
        return ((t / tiles) * s + p / s) * 128 + (t % tiles) * s + p % s;
    endfunction

    function automatic int exp_checksum();
        int s = 0;
`ifdef SAO_RB_CHECKSUM_EN
        for (int i = 0; i < N; i++) s += int'(mem[i]);
        s = s & 32'hffff;
`endif
        return s;
    endfunction

    task automatic sample();
        int ea;
        if (bus.cen == 1'b0) begin
            iss++;
            if (first_cen < 0) first_cen = cyc;
        end
        if (bus.out_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall) begin
            check_eq("stall_data", 32'(bus.out_data), 32'(held_d));
            check_eq("stall_addr", 32'(bus.out_addr), 32'(held_a));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (pix < N) begin
                ea = exp_addr(cur_mode, cur_s, pix);
                check_eq("pix_addr", 32'(bus.out_addr), ea);
                check_eq("pix_data", 32'(bus.out_data), 32'(mem[ea]));
                obs_addr[pix] = int'(bus.out_addr);
            end
            pix++;
        end
        check_eq("outstanding_le2", 32'((iss - pix) <= 2), 1);
        prev_stall = bus.out_valid && !bus.out_ready;
        held_d     = bus.out_data;
        held_a     = bus.out_addr;
        if (o_done) begin
            done_cnt++;
            done_cyc   = cyc;
            cs_at_done = int'(o_checksum);
            check_eq("busy_at_done", 32'(o_busy), 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        i_start = 1'b0;
        bus.out_ready = rnd_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
        @(negedge clk);
        sample();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_cen", 32'(bus.cen), 1);
        check_eq("rst_wen", 32'(bus.wen), 1);
        check_eq("rst_a", 32'(bus.a), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);
        check_eq("rst_out_addr", 32'(bus.out_addr), 0);
        check_eq("rst_busy", 32'(o_busy), 0);
        check_eq("rst_done", 32'(o_done), 0);
        check_eq("rst_checksum", 32'(o_checksum), 0);
    endtask

    task automatic run_frame(input bit mode, input logic [1:0] lcu, input bit rnd,
                             input int abort_pix, input int restart_pix);
        int  t0, budget, exp_cs;
        bit  pulsed, aborted;
        cur_mode = mode;
        cur_s = 16 << lcu;
        pix = 0; iss = 0; first_cen = -1; first_valid = -1;
        done_cnt = 0; done_cyc = -1; prev_stall = 1'b0; rnd_ready = rnd;
        pulsed = 1'b0; aborted = 1'b0; budget = 0;
        i_scan_mode = mode;
        i_lcu_size  = lcu;
        i_start     = 1'b1;
        t0 = cyc;
        while (done_cnt == 0 && budget < 70000) begin
            step();
            budget++;
            if (abort_pix >= 0 && pix >= abort_pix) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                @(negedge clk);
                check_reset_vals();
                prev_stall = 1'b0; iss = 0; pix = 0;
                for (int i = 0; i < 4; i++) begin
                    step();
                    check_eq("abort_busy", 32'(o_busy), 0);
                end
                check_eq("abort_no_done", done_cnt, 0);
                aborted = 1'b1;
                break;
            end
            if (restart_pix >= 0 && !pulsed && pix >= restart_pix) begin
                i_start     = 1'b1;
                i_scan_mode = ~mode;
                i_lcu_size  = 2'd2;
                pulsed      = 1'b1;
            end
        end
        if (!aborted) begin
            exp_cs = exp_checksum();
            check_eq("done_seen", done_cnt, 1);
            check_eq("pix_count", pix, N);
            check_eq("first_issue_cyc", first_cen, t0 + 1);
            check_eq("first_valid_cyc", first_valid, t0 + 3);
            if (!rnd) check_eq("done_cyc", done_cyc, t0 + 16387);
            check_eq("checksum", cs_at_done, exp_cs);
            step();
            check_eq("busy_after_done", 32'(o_busy), 0);
            check_eq("checksum_hold", 32'(o_checksum), exp_cs);
            repeat (3) step();
            check_eq("done_once", done_cnt, 1);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit exceeded at cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        reset = 1'b1;
        i_start = 1'b0;
        i_scan_mode = 1'b0;
        i_lcu_size = 2'd0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        // lcu_size 3 must be rejected
        i_lcu_size = 2'd3;
        i_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("lcu3_busy", 32'(o_busy), 0);
            check_eq("lcu3_cen", 32'(bus.cen), 1);
        end

        run_frame(1'b0, 2'd0, 1'b0, 8000, -1);
        run_frame(1'b1, 2'd0, 1'b0, 2500, -1);
        run_frame(1'b1, 2'd2, 1'b0, 5000, -1);
        run_frame(1'b0, 2'd0, 1'b0, -1, -1);

        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        run_frame(1'b1, 2'd1, 1'b1, -1, 500);
        check_eq("tile_pix32", obs_addr[32], 128);
        check_eq("tile_pix1024", obs_addr[1024], 32);
        check_eq("tile_pix4096", obs_addr[4096], 4096);
        check_eq("tile_last", obs_addr[N-1], 16383);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
